// File: rtl/avgiq_pkg.sv
// Shared types and helpers for the averaged-IQ capture path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package avgiq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Bit positions of the flags in the software-visible status/address word
  localparam int DONE_BIT = 31;
  localparam int BUSY_BIT = 30;

  // Limit the requested averaging exponent to what the accumulators can hold
  function automatic logic [3:0] clamp_log2(input logic [3:0] n, input logic [3:0] max_n);
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/avgiq_accum.sv
// One signed accumulator producing the 2^N shift-average of its inputs.
// Latency: avg is combinational from the current sample plus the running sum.
// Backpressure: none; accumulates whenever en is high.
module avgiq_accum #(
  parameter int DATA_W   = 16,
  parameter int MAX_LOG2 = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     last,
  input  logic [3:0]               n_log2,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] avg
);

  localparam int ACC_W = DATA_W + MAX_LOG2;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] din_ext;
  logic signed [ACC_W-1:0] sum;

  // Running sum including the sample on the bus; the average is the floor of sum/2^N
  always_comb begin
    din_ext = {{MAX_LOG2{din[DATA_W-1]}}, din};
    sum     = acc_q + din_ext;
    avg     = DATA_W'(sum >>> n_log2);
    acc_d   = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      // The final sample of a block restarts the sum at zero for the next block
      acc_d = last ? '0 : sum;
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/avgiq_capture_ctrl.sv
// Selects one channel, averages 2^N I/Q samples per entry and writes averages to the buffer.
// Latency: final accepted sample -> bram_we next cycle; status count updates one cycle later.
// Backpressure: none; input is a free-running stream, non-selected samples are dropped.
module avgiq_capture_ctrl
  import avgiq_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int CH_W     = 8,
  parameter int MAX_LOG2 = 8
) (
  input  logic                     user_clk,
  input  logic                     user_rst,
  input  logic                     start,
  input  logic [3:0]               n_avg_log2,
  input  logic [CH_W-1:0]          ch_sel,
  input  logic                     sync_in,
  input  logic                     din_valid,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic signed [DATA_W-1:0] din_q,
  output logic                     bram_we,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic [2*DATA_W-1:0]      bram_data,
  output logic [31:0]              avgiq_addr
);

  state_e state_q, state_d;

  logic                  start_prev_q, start_prev_d;
  logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d;
  logic [CH_W-1:0]       ch_sel_q, ch_sel_d;
  logic [3:0]            n_q, n_d;
  logic [MAX_LOG2:0]     smp_cnt_q, smp_cnt_d;
  logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       wr_cnt_q, wr_cnt_d;
  logic                  bram_we_q, bram_we_d;
  logic [ADDR_W-1:0]     bram_addr_q, bram_addr_d;
  logic [2*DATA_W-1:0]   bram_data_q, bram_data_d;

  logic                  start_edge;
  logic                  arm_go;
  logic [CH_W-1:0]       cur_ch;
  logic                  accept;
  logic [MAX_LOG2:0]     smp_tgt;
  logic                  smp_last;
  logic                  final_acc;
  logic                  last_write;
  logic signed [DATA_W-1:0] avg_i, avg_q;
  logic                  busy, done;

  // Control decode shared by the state machine and the datapath
  always_comb begin
    start_edge = start & ~start_prev_q;
    arm_go     = start_edge && (state_q == ST_IDLE || state_q == ST_DONE);
    // A sync cycle carries channel 0 regardless of where the counter was
    cur_ch     = sync_in ? '0 : ch_cnt_q;
    // wr_ptr MSB set means every entry has been issued; stop taking samples
    accept     = din_valid && (cur_ch == ch_sel_q) && !wr_ptr_q[ADDR_W] &&
                 ((state_q == ST_RUN) || (state_q == ST_ARM && sync_in));
    smp_tgt    = (MAX_LOG2+1)'(1) << n_q;
    smp_last   = (smp_cnt_q + (MAX_LOG2+1)'(1)) == smp_tgt;
    final_acc  = accept && smp_last;
    last_write = bram_we_q && (bram_addr_q == '1);
  end

  // State register
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arm_go)     state_d = ST_ARM;
      ST_ARM:  if (sync_in)    state_d = ST_RUN;
      ST_RUN:  if (last_write) state_d = ST_DONE;
      ST_DONE: if (arm_go)     state_d = ST_ARM;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Status outputs derived from state and the completed-write count
  always_comb begin
    busy       = (state_q == ST_ARM) || (state_q == ST_RUN);
    done       = (state_q == ST_DONE);
    avgiq_addr = '0;
    avgiq_addr[ADDR_W:0] = wr_cnt_q;
    avgiq_addr[DONE_BIT] = done;
    avgiq_addr[BUSY_BIT] = busy;
    bram_we    = bram_we_q;
    bram_addr  = bram_addr_q;
    bram_data  = bram_data_q;
  end

  // Datapath next values: edge detect, channel tracking, sample/write counters
  always_comb begin
    start_prev_d = start;

    ch_cnt_d = ch_cnt_q;
    if (din_valid) begin
      ch_cnt_d = sync_in ? CH_W'(1) : ch_cnt_q + CH_W'(1);
    end else if (sync_in) begin
      ch_cnt_d = '0;
    end

    // Configuration is sampled only when arming so mid-capture changes are ignored
    n_d      = arm_go ? clamp_log2(n_avg_log2, 4'(MAX_LOG2)) : n_q;
    ch_sel_d = arm_go ? ch_sel : ch_sel_q;

    smp_cnt_d = smp_cnt_q;
    if (arm_go) begin
      smp_cnt_d = '0;
    end else if (accept) begin
      smp_cnt_d = smp_last ? '0 : smp_cnt_q + (MAX_LOG2+1)'(1);
    end

    // wr_ptr tracks issued writes so back-to-back writes get distinct addresses
    wr_ptr_d = wr_ptr_q;
    if (arm_go) begin
      wr_ptr_d = '0;
    end else if (final_acc) begin
      wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
    end

    // wr_cnt is the software-visible count and advances on the write strobe itself
    wr_cnt_d = wr_cnt_q;
    if (arm_go) begin
      wr_cnt_d = '0;
    end else if (bram_we_q) begin
      wr_cnt_d = wr_cnt_q + (ADDR_W+1)'(1);
    end

    bram_we_d   = final_acc;
    bram_addr_d = final_acc ? wr_ptr_q[ADDR_W-1:0] : bram_addr_q;
    bram_data_d = final_acc ? {avg_i, avg_q} : bram_data_q;
  end

  // Datapath registers
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      start_prev_q <= 1'b0;
      ch_cnt_q     <= '0;
      ch_sel_q     <= '0;
      n_q          <= '0;
      smp_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      wr_cnt_q     <= '0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_data_q  <= '0;
    end else begin
      start_prev_q <= start_prev_d;
      ch_cnt_q     <= ch_cnt_d;
      ch_sel_q     <= ch_sel_d;
      n_q          <= n_d;
      smp_cnt_q    <= smp_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_cnt_q     <= wr_cnt_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_data_q  <= bram_data_d;
    end
  end

  avgiq_accum #(.DATA_W(DATA_W), .MAX_LOG2(MAX_LOG2)) u_acc_i (
    .clk    (user_clk),
    .rst    (user_rst),
    .clr    (arm_go),
    .en     (accept),
    .last   (smp_last),
    .n_log2 (n_q),
    .din    (din_i),
    .avg    (avg_i)
  );

  avgiq_accum #(.DATA_W(DATA_W), .MAX_LOG2(MAX_LOG2)) u_acc_q (
    .clk    (user_clk),
    .rst    (user_rst),
    .clr    (arm_go),
    .en     (accept),
    .last   (smp_last),
    .n_log2 (n_q),
    .din    (din_q),
    .avg    (avg_q)
  );

endmodule

// File: doc/avgiq_capture_ctrl.md
# avgiq_capture_ctrl

Capture sequencer for the averaged-IQ snapshot path of the channelizer. It selects one channel from the channelized stream and accumulates 2^N samples of I and Q per entry. Each average is written to the avgIQ buffer BRAM, and a status/address word is published for the software-readable avgIQ address register. It lives in the user (DSP) clock domain; all buffer and status signals are produced here for the bus-side register and BRAM.

## Interface
Parameters:
- ADDR_W, 10: buffer address width; capture length 2^ADDR_W entries
- DATA_W, 16: I/Q sample width, signed
- CH_W, 8: channel index width
- MAX_LOG2, 8: largest allowed averaging exponent

Ports:
- user_clk  in  1  sole clock
- user_rst  in  1  synchronous, active-high reset
- start  in  1  level from software; rising edge arms a capture
- n_avg_log2  in  4  averaging exponent N; values above MAX_LOG2 clamp to MAX_LOG2
- ch_sel  in  CH_W  channel to capture
- sync_in  in  1  frame start; sample present on this cycle is channel 0
- din_valid  in  1  one channel sample present
- din_i, din_q  in  DATA_W each  signed samples
- bram_we  out  1  buffer write strobe
- bram_addr  out  ADDR_W  buffer write address
- bram_data  out  2*DATA_W  {avg_i, avg_q}
- avgiq_addr  out  32  status word: [31] done, [30] busy, [ADDR_W:0] entries written, other bits 0

## Operation
- States: IDLE, ARM, RUN, DONE. Reset -> IDLE; all outputs 0; accumulators, counters and edge detector cleared.
- start edge: the previous-cycle start is registered; an edge is start=1 with prev=0. An edge in IDLE or DONE -> ARM. Entering ARM latches N (clamped) and ch_sel, and clears the write count and done. Edges in ARM or RUN are ignored.
- Channel counter: increments on din_valid and wraps at 2^CH_W. On sync_in with din_valid, the current sample is channel 0 and the counter becomes 1. Without din_valid, sync_in sets the counter to 0.
- ARM -> RUN on sync_in.
- Accept: din_valid, channel index = latched ch_sel, and either state=RUN or (state=ARM and sync_in).
- Each accepted sample adds to acc_i/acc_q, which are DATA_W+MAX_LOG2 bits, signed and sign-extended. A sample counter counts to 2^N.
- On the 2^N-th accepted sample, both sums are final: sum = acc + sample. The average is sum >>> N (arithmetic shift), truncated to DATA_W; it cannot overflow. acc and the sample counter clear together with that accept.
- N=0: every accepted sample is written unchanged.
- After write address 2^ADDR_W-1: RUN -> DONE, done=1, busy=0. DONE holds until the next start edge or reset.
- busy=1 in ARM and RUN.
- sync_in in RUN only realigns the channel counter; the averaging in progress continues.

## Timing
- Accept on the final sample at cycle t -> bram_we=1 at t+1, with bram_addr = write index and bram_data registered. bram_we is a single-cycle pulse.
- Write index increments after each write. avgiq_addr[ADDR_W:0] shows the new count at t+2.
- done rises at t+2 of the last write; busy falls in the same cycle.
- Maximum throughput: one write per cycle when N=0 and every sample matches, which requires CH_W=0 or a single-channel stream.
- Reset mid-capture: next cycle IDLE, bram_we=0, avgiq_addr=0. Writes already made to the BRAM are not undone.
- Start edge to ARM: 1 cycle. Register changes in ARM or RUN have no effect until the next arm.

## Structure
- Shared package avgiq_pkg: state enum, status bit positions (DONE_BIT=31, BUSY_BIT=30), and a clamp function for N.
- One natural sub-module: avgiq_accum. It holds one signed accumulator with a shift-average output and is instantiated twice (I and Q). The state machine, counters and status word stay at top level.

## Test plan
- Basic capture, ADDR_W=2, N=2, ch_sel=3, 8 channels/frame. Channel-3 samples I=4,8,12,16, Q=-4,-4,-4,-4 -> first write {10,-4} at addr 0. After 4 writes, avgiq_addr = 0x8000_0004.
- Negative rounding, N=1. I samples -3 and -2 -> avg_i = -3 (floor, arithmetic shift).
- N=0 passthrough. Sample I=0x7FFF, Q=0x8000 -> bram_data=0x7FFF_8000 one cycle after accept.
- Arming: start edge, then samples for ch_sel before any sync_in -> no writes, busy=1. The first sync_in with matching ch_sel=0 counts that same cycle's sample.
- start held high through DONE -> no re-arm. Toggling start 0->1 clears done and the count, giving avgiq_addr=0x4000_0000.
- user_rst asserted mid-RUN after 2 writes -> next cycle avgiq_addr=0 and bram_we=0. A following start edge captures from addr 0.
